// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder.
//   SLICE_W  : width of the shared lookahead slice (one nibble)
//   state_t  : controller states
//   idx_w()  : bit width needed to index every slice of a WIDTH-bit operand
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // clog2(width / SLICE_W), with a floor of 1 so the index always exists.
    function automatic int idx_w(input int width);
        int n;
        int w;
        n = width / SLICE_W;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Purely combinational 4-bit carry-lookahead slice.
// Ports:
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum
//   c    : carry out of each bit; c[3] is the slice carry-out
module cla4_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic [SLICE_W-1:0] c
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products from cin, so the depth does not
    // grow with bit position.
    assign c[0] = g[0] | (p[0] & cin);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s[0] = p[0] ^ cin;
    assign s[1] = p[1] ^ c[0];
    assign s[2] = p[2] ^ c[1];
    assign s[3] = p[3] ^ c[2];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder built around one shared 4-bit lookahead slice.
// One nibble is added per clock, with the inter-slice carry held in a register.
//
// State table:
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | adding nibble idx_q, sum partial
//   DONE  | sum/cout (and ovf) final, out_valid high until out_ready
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   ovf                 : signed overflow, only when CLA_SEQ_OVF_EN is defined
//
// Build option: define CLA_SEQ_OVF_EN to add the ovf output and register.
// WIDTH must be a multiple of 4 and at least 8.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int IDX_W = idx_w(WIDTH);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef CLA_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic [SLICE_W-1:0] slice_c;
    logic               last_slice;

    // Operand nibble select: a compare per slice keeps every part-select constant.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cla4_slice u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .s   (slice_s),
        .c   (slice_c)
    );

    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CLA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef CLA_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = slice_s;
                    end
                end
                carry_d = slice_c[SLICE_W-1];
                idx_d   = idx_q + 1'b1;
                if (last_slice) begin
                    // Explicit clear: NSLICE need not be a power of two.
                    idx_d   = '0;
                    cout_d  = slice_c[SLICE_W-1];
`ifdef CLA_SEQ_OVF_EN
                    // Carry into the MSB differs from carry out of it.
                    ovf_d   = slice_c[SLICE_W-1] ^ slice_c[SLICE_W-2];
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CLA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

`ifndef CLA_SEQ_OVF_EN
    // Internal slice carries only matter for overflow detection.
    logic unused_slice_c;
    assign unused_slice_c = ^slice_c[SLICE_W-2:0];
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CLA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_SEQ_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operation, confirm the 4-edge latency and the final result,
    // leaving the DUT in DONE with out_ready low.
    task automatic start_op(input string tag,
                            input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                            input logic op_cin);
        int cycles;
        @(negedge clk);
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
        cycles   = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'd4);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] exp_sum,
                                input logic exp_cout, input logic exp_ovf);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef CLA_SEQ_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $error("FAIL %s_ovf_arg: unknown expectation", tag);
`endif
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ret_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_ret_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'h0000);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef CLA_SEQ_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add.
        start_op("basic", 16'h1234, 16'h4321, 1'b0);
        check_result("basic", 16'h5555, 1'b0, 1'b0);
        handshake("basic");

        // Carry ripples through every slice via the carry register.
        start_op("fullc", 16'hFFFF, 16'h0000, 1'b1);
        check_result("fullc", 16'h0000, 1'b1, 1'b0);
        handshake("fullc");

        // All-ones plus all-ones plus carry-in.
        start_op("ones", 16'hFFFF, 16'hFFFF, 1'b1);
        check_result("ones", 16'hFFFF, 1'b1, 1'b0);
        handshake("ones");

        // Signed overflow, positive side.
        start_op("ovfp", 16'h7FFF, 16'h0001, 1'b0);
        check_result("ovfp", 16'h8000, 1'b0, 1'b1);
        handshake("ovfp");

        // Signed overflow, negative side.
        start_op("ovfn", 16'h8000, 16'h8000, 1'b0);
        check_result("ovfn", 16'h0000, 1'b1, 1'b1);
        handshake("ovfn");

        // Back-pressure: result held, in_valid ignored while DONE.
        start_op("bp", 16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            a        = 16'h0001;
            b        = 16'h0000;
            cin      = 1'b0;
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'h3333);
            check("bp_cout", 32'(cout), 32'd0);
        end
        in_valid = 1'b0;
        handshake("bp");

        start_op("after_bp", 16'hABCD, 16'h1234, 1'b1);
        check_result("after_bp", 16'hBE02, 1'b0, 1'b0);
        handshake("after_bp");

        // Reset during RUN discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_in_run", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'h0000);
        check("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op("post_rst", 16'h00FF, 16'h0001, 1'b0);
        check_result("post_rst", 16'h0100, 1'b0, 1'b0);
        handshake("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
